prog_loader: RTL and testbench
==============================

# prog_loader

Host-side program loader and run sequencer for the single-cycle core. It accepts a stream of 9-bit instruction words and writes them into the instruction memory's write port at consecutive addresses from 0. It then releases the core's `start` line and waits for `done`, counting execution cycles. It is the writer and initiator for the core's instruction-fetch and start/done interfaces.

## Interface
- `INSTR_W`, 9: instruction word width.
- `ADDR_W`, 12: instruction memory address width.
- `CYC_W`, 16: run-cycle counter width.
- `MAX_CYCLES`, 16'hFFFF: timeout threshold in RUN cycles; only used with the timeout feature.

- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `load_req` in 1: begin a new load; accepted only in IDLE or FINISH.
- `in_valid` in 1: instruction word valid.
- `in_ready` out 1: loader accepts a word.
- `in_data` in INSTR_W: instruction word.
- `in_last` in 1: final word of the program.
- `im_wen` out 1: instruction memory write enable.
- `im_waddr` out ADDR_W: write address.
- `im_wdata` out INSTR_W: write data.
- `cpu_start` out 1: core start/hold line; high holds the PC at 0.
- `cpu_done` in 1: core completion flag.
- `busy` out 1: high in LOAD, ARM and RUN.
- `prog_len` out ADDR_W+1: number of words written in the last load (1..4096).
- `run_cycles` out CYC_W: number of RUN cycles until done was seen.
- `run_ok` out 1: the last run ended on `cpu_done`.
- `timeout` out 1: the last run ended on the timeout.

## Operation
- FSM states: IDLE, LOAD, ARM, RUN, FINISH.
- IDLE → LOAD when `load_req` is high.
  - On entry to LOAD: clear the word address to 0, and clear `prog_len`, `run_cycles`, `run_ok` and `timeout`.
- LOAD:
  - `in_ready` = 1.
  - A handshake is `in_valid & in_ready`. On each handshake, register the write (`im_wen`=1, address, data), increment the address, and increment `prog_len`.
  - A handshake with `in_last`=1, or with the address at 4095, moves the FSM to ARM. Address 4095 is an implicit last; the address never wraps.
- ARM: one cycle so the final registered write lands. `cpu_start` stays high. Moves to RUN.
- RUN:
  - `cpu_start` = 0, and `run_cycles` increments every cycle.
  - `cpu_done` is ignored in the first RUN cycle, because it may be stale from the previous run.
  - From the second RUN cycle, `cpu_done`=1 sets `run_ok`=1 and moves to FINISH.
- FINISH: `cpu_start` = 1 and all status outputs hold. `load_req` restarts at LOAD.
- `load_req` in LOAD, ARM or RUN is ignored.
- `in_ready` = 0 in every state except LOAD; `in_valid` outside LOAD has no effect.
- `cpu_start` is high in every state except RUN.
- `run_cycles` saturates at all-ones and never wraps.
- If `cpu_done` and the timeout condition occur in the same cycle, `cpu_done` wins: `run_ok`=1, `timeout`=0.

## Timing
- Reset values:
  - FSM = IDLE.
  - `cpu_start`=1.
  - `in_ready`=0, `im_wen`=0, `im_waddr`=0, `im_wdata`=0.
  - `busy`=0, `prog_len`=0, `run_cycles`=0, `run_ok`=0, `timeout`=0.
- Reset mid-operation (any state) returns to IDLE immediately. Memory already written is not cleared.
- `in_ready` is a registered decode of the state. It rises the cycle after `load_req` is sampled in IDLE or FINISH.
- Write latency is 1 cycle: a handshake at edge N gives `im_wen`/`im_waddr`/`im_wdata` valid in cycle N+1.
- Last handshake at edge N: ARM in cycle N+1, RUN (`cpu_start`=0) in cycle N+2.
- `cpu_done` is sampled at the clock edge. `cpu_start` rises in the cycle after `cpu_done` is seen.
- All outputs are registered except `busy`, which is a decode of the state register.

## Configuration
- `PROG_LOADER_TIMEOUT_EN`, when defined:
  - When `run_cycles` reaches `MAX_CYCLES` without `cpu_done`, set `timeout`=1 and move to FINISH.
- When not defined:
  - No timeout logic is built and `timeout` is tied to 0.
  - RUN waits indefinitely for `cpu_done`; `run_cycles` still saturates.

## Structure
- `prog_loader_pkg` holds:
  - the `INSTR_W`/`ADDR_W`/`CYC_W` defaults;
  - the state enum `ldr_state_t`;
  - the constant `LAST_ADDR` = 4095.
- One sub-module, `sat_counter`: parameterized width, synchronous clear, enable, saturate-at-max. It is used for `run_cycles`.

## Test plan
- Reset while in RUN: assert `reset` → same cycle `cpu_start`=1, `in_ready`=0, `prog_len`=0; FSM = IDLE.
- Load 3 words 0x1A0, 0x055, 0x1FF with `in_last` on the third → `im_wen` pulses at addresses 0,1,2 with that data; `prog_len`=3; `cpu_start` low 2 cycles after the last handshake.
- `in_valid` toggling 1,0,1,1 during LOAD → only 3 writes, at consecutive addresses with no gaps; a stale `in_data` during `in_valid`=0 is never written.
- Stream 4096 words with `in_last` never asserted → the write at 4095 ends the load; `prog_len`=4096; `in_ready`=0 afterward.
- Hold `cpu_done`=1 during the first RUN cycle, drop it, then raise it again 10 cycles into RUN → ignored the first time; FINISH with `run_ok`=1, `run_cycles`=10.
- With `PROG_LOADER_TIMEOUT_EN` and `MAX_CYCLES`=20, `cpu_done` never rises → `timeout`=1, `run_ok`=0, `run_cycles`=20; a following `load_req` reaches LOAD and clears the status.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: default widths, FSM encoding and the final instruction address
// shared by the program loader and its bench.
package prog_loader_pkg;

  localparam int INSTR_W_DEF = 9;
  localparam int ADDR_W_DEF  = 12;
  localparam int CYC_W_DEF   = 16;
  localparam int LAST_ADDR   = 4095;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_RUN,
    ST_FINISH
  } ldr_state_t;

endpackage

// File: rtl/prog_loader_sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones instead of
// wrapping; counts the core's run cycles.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // NOTE: count_d takes a default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams instruction words into the core's instruction memory, then runs
// the core until done. Optional run timeout is built when PROG_LOADER_TIMEOUT_EN is defined.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          INSTR_W    = INSTR_W_DEF,
  parameter int          ADDR_W     = ADDR_W_DEF,
  parameter int          CYC_W      = CYC_W_DEF,
  parameter int unsigned MAX_CYCLES = 32'h0000_FFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_req,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_data,
  input  logic               in_last,
  output logic               im_wen,
  output logic [ADDR_W-1:0]  im_waddr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_start,
  input  logic               cpu_done,
  output logic               busy,
  output logic [ADDR_W:0]    prog_len,
  output logic [CYC_W-1:0]   run_cycles,
  output logic               run_ok,
  output logic               timeout
);

  localparam logic [CYC_W-1:0] TIMEOUT_AT = CYC_W'(MAX_CYCLES - 1);

  ldr_state_t state_q, state_d;

  logic               in_ready_q, cpu_start_q, im_wen_q, run_ok_q;
  logic [ADDR_W-1:0]  im_waddr_q;
  logic [INSTR_W-1:0] im_wdata_q;
  logic [ADDR_W:0]    prog_len_q;
  logic [CYC_W-1:0]   run_cnt;
  logic               in_run, load_start, hs, at_last, done_hit, to_hit;

  assign in_run     = (state_q == ST_RUN);
  assign load_start = load_req && ((state_q == ST_IDLE) || (state_q == ST_FINISH));
  assign hs         = in_valid && in_ready_q && (state_q == ST_LOAD);
  // The word count doubles as the next write address.
  assign at_last    = (prog_len_q == (ADDR_W+1)'(LAST_ADDR));
  // The counter is still 0 in the first RUN cycle, which masks a done left over from the last run.
  assign done_hit   = in_run && cpu_done && (run_cnt != '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_FINISH: if (load_req) state_d = ST_LOAD;
      ST_LOAD:            if (hs && (in_last || at_last)) state_d = ST_ARM;
      ST_ARM:             state_d = ST_RUN;
      ST_RUN:             if (done_hit || to_hit) state_d = ST_FINISH;
      default:            state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      cpu_start_q <= 1'b1;
      im_wen_q    <= 1'b0;
      im_waddr_q  <= '0;
      im_wdata_q  <= '0;
      prog_len_q  <= '0;
      run_ok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == ST_LOAD);
      cpu_start_q <= (state_d != ST_RUN);
      im_wen_q    <= hs;
      if (hs) begin
        im_waddr_q <= prog_len_q[ADDR_W-1:0];
        im_wdata_q <= in_data;
      end
      if (load_start)  prog_len_q <= '0;
      else if (hs)     prog_len_q <= prog_len_q + 1'b1;
      if (load_start)    run_ok_q <= 1'b0;
      else if (done_hit) run_ok_q <= 1'b1;
    end
  end

  sat_counter #(
    .W (CYC_W)
  ) u_run_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (load_start),
    .en    (in_run),
    .count (run_cnt)
  );

`ifdef PROG_LOADER_TIMEOUT_EN
  logic timeout_q;

  // Fires on the edge that brings the counter to MAX_CYCLES; a same-cycle done takes priority.
  assign to_hit = in_run && (run_cnt == TIMEOUT_AT) && !done_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           timeout_q <= 1'b0;
    else if (load_start) timeout_q <= 1'b0;
    else if (to_hit)     timeout_q <= 1'b1;
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_at;

  assign to_hit            = 1'b0;
  assign timeout           = 1'b0;
  assign unused_timeout_at = ^TIMEOUT_AT;
`endif

  assign busy       = (state_q == ST_LOAD) || (state_q == ST_ARM) || (state_q == ST_RUN);
  assign in_ready   = in_ready_q;
  assign cpu_start  = cpu_start_q;
  assign im_wen     = im_wen_q;
  assign im_waddr   = im_waddr_q;
  assign im_wdata   = im_wdata_q;
  assign prog_len   = prog_len_q;
  assign run_cycles = run_cnt;
  assign run_ok     = run_ok_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed and randomized loads/runs of prog_loader checked against a
// word-list and done-sequence model of the loader's behaviour.
module tb_prog_loader;

  localparam int INSTR_W = 9;
  localparam int ADDR_W  = 12;
  localparam int CYC_W   = 16;
`ifdef PROG_LOADER_TIMEOUT_EN
  localparam int MAXC = 20;
`else
  localparam int MAXC = 65535;
`endif

  logic               clk      = 1'b0;
  logic               reset    = 1'b1;
  logic               load_req = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_last  = 1'b0;
  logic               cpu_done = 1'b0;
  logic [INSTR_W-1:0] in_data  = '0;
  logic               in_ready, im_wen, cpu_start, busy, run_ok, timeout;
  logic [ADDR_W-1:0]  im_waddr;
  logic [INSTR_W-1:0] im_wdata;
  logic [ADDR_W:0]    prog_len;
  logic [CYC_W-1:0]   run_cycles;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W-1:0]  wa_q[$];
  logic [INSTR_W-1:0] wd_q[$];
  logic [INSTR_W-1:0] words_q[$];
  bit                 vpat_q[$];
  bit                 seq_q[$];

  prog_loader #(
    .INSTR_W    (INSTR_W),
    .ADDR_W     (ADDR_W),
    .CYC_W      (CYC_W),
    .MAX_CYCLES (MAXC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_req   (load_req),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .im_wen     (im_wen),
    .im_waddr   (im_waddr),
    .im_wdata   (im_wdata),
    .cpu_start  (cpu_start),
    .cpu_done   (cpu_done),
    .busy       (busy),
    .prog_len   (prog_len),
    .run_cycles (run_cycles),
    .run_ok     (run_ok),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Memory-side observer: every write the loader issues, in order.
  always @(negedge clk) begin
    if (im_wen === 1'b1) begin
      wa_q.push_back(im_waddr);
      wd_q.push_back(im_wdata);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_words(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back(INSTR_W'($urandom));
  endtask

  // Random done pattern for a run; the last entry is always a done.
  task automatic make_rand_seq();
    int len;
    len = int'($urandom_range(15, 3));
    seq_q.delete();
    for (int i = 0; i < len; i++) seq_q.push_back($urandom_range(99) < 20);
    seq_q[len-1] = 1'b1;
  endtask

  // Load words_q; vpat_q (if any) fixes in_valid per cycle before random gaps take over.
  // Returns in the first RUN cycle.
  task automatic do_load(input string tag, input int gap_pct, input bit use_last);
    int sent, cyc, e0;
    bit v;
    logic [INSTR_W-1:0] exp_q[$];
    sent = 0;
    cyc  = 0;
    wa_q.delete();
    wd_q.delete();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check($sformatf("%s_in_ready_rise", tag), 32'(in_ready), 32'd1);
    check($sformatf("%s_busy_load", tag), 32'(busy), 32'd1);
    check($sformatf("%s_prog_len_clr", tag), 32'(prog_len), 32'd0);
    check($sformatf("%s_run_cycles_clr", tag), 32'(run_cycles), 32'd0);
    check($sformatf("%s_run_ok_clr", tag), 32'(run_ok), 32'd0);
    check($sformatf("%s_timeout_clr", tag), 32'(timeout), 32'd0);
    while (sent < words_q.size()) begin
      if (cyc < vpat_q.size()) v = vpat_q[cyc];
      else                     v = (int'($urandom_range(99)) >= gap_pct);
      in_valid = v;
      in_data  = v ? words_q[sent] : INSTR_W'($urandom);
      in_last  = v && use_last && (sent == words_q.size() - 1);
      load_req = 1'($urandom_range(1));
      if (v) begin
        exp_q.push_back(words_q[sent]);
        sent++;
      end
      cyc++;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    load_req = 1'b0;
    in_data  = INSTR_W'($urandom);
    check($sformatf("%s_arm_cpu_start", tag), 32'(cpu_start), 32'd1);
    check($sformatf("%s_arm_in_ready", tag), 32'(in_ready), 32'd0);
    check($sformatf("%s_arm_busy", tag), 32'(busy), 32'd1);
    tick();
    check($sformatf("%s_run_cpu_start", tag), 32'(cpu_start), 32'd0);
    check($sformatf("%s_run_in_ready", tag), 32'(in_ready), 32'd0);
    check($sformatf("%s_prog_len", tag), 32'(prog_len), 32'(exp_q.size()));
    check($sformatf("%s_write_count", tag), 32'(wa_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wa_q.size(); i++) begin
      e0 = n_errors;
      check($sformatf("%s_waddr[%0d]", tag, i), 32'(wa_q[i]), 32'(i));
      check($sformatf("%s_wdata[%0d]", tag, i), 32'(wd_q[i]), 32'(exp_q[i]));
      if (n_errors != e0) break;
    end
  endtask

  // Drive seq_q on cpu_done starting in the first RUN cycle, with noise on the other inputs.
  task automatic do_run(input string tag);
    int k, stop;
    bit exp_to;
    k = 0;
    for (int i = 1; i < seq_q.size(); i++) if (seq_q[i] && (k == 0)) k = i + 1;
    exp_to = 1'b0;
    stop   = (k == 0) ? seq_q.size() : k;
`ifdef PROG_LOADER_TIMEOUT_EN
    if ((k == 0) || (k > MAXC)) begin
      exp_to = 1'b1;
      stop   = MAXC;
    end
`endif
    wa_q.delete();
    wd_q.delete();
    for (int i = 1; i <= stop; i++) begin
      cpu_done = (i <= seq_q.size()) ? seq_q[i-1] : 1'b0;
      in_valid = 1'($urandom_range(1));
      in_data  = INSTR_W'($urandom);
      load_req = 1'($urandom_range(1));
      tick();
    end
    cpu_done = 1'b0;
    in_valid = 1'b0;
    load_req = 1'b0;
    check($sformatf("%s_cpu_start", tag), 32'(cpu_start), 32'd1);
    check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s_in_ready", tag), 32'(in_ready), 32'd0);
    check($sformatf("%s_run_ok", tag), 32'(run_ok), 32'(!exp_to));
    check($sformatf("%s_timeout", tag), 32'(timeout), 32'(exp_to));
    check($sformatf("%s_run_cycles", tag), 32'(run_cycles), 32'(stop));
    check($sformatf("%s_no_write", tag), 32'(wa_q.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_start", 32'(cpu_start), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_im_wen", 32'(im_wen), 32'd0);
    check("rst_im_waddr", 32'(im_waddr), 32'd0);
    check("rst_im_wdata", 32'(im_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_prog_len", 32'(prog_len), 32'd0);
    check("rst_run_cycles", 32'(run_cycles), 32'd0);
    check("rst_run_ok", 32'(run_ok), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    tick();

    // Words offered in IDLE must be ignored.
    wa_q.delete();
    in_valid = 1'b1;
    in_data  = 9'h0AA;
    in_last  = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_no_write", 32'(wa_q.size()), 32'd0);

    // Three-word program, then stale done in RUN cycle 1 and a real done in cycle 10.
    words_q.delete();
    words_q.push_back(9'h1A0);
    words_q.push_back(9'h055);
    words_q.push_back(9'h1FF);
    vpat_q.delete();
    do_load("load3", 0, 1'b1);
    seq_q.delete();
    seq_q.push_back(1'b1);
    for (int i = 0; i < 8; i++) seq_q.push_back(1'b0);
    seq_q.push_back(1'b1);
    do_run("done10");

    // in_valid pattern 1,0,1,1 with stale data in the gap.
    rand_words(3);
    vpat_q.delete();
    vpat_q.push_back(1'b1);
    vpat_q.push_back(1'b0);
    vpat_q.push_back(1'b1);
    vpat_q.push_back(1'b1);
    do_load("toggle", 0, 1'b1);
    vpat_q.delete();
    make_rand_seq();
    do_run("toggle_run");

    for (int r = 0; r < 4; r++) begin
      rand_words(int'($urandom_range(24, 1)));
      do_load($sformatf("rand%0d", r), 35, 1'b1);
      make_rand_seq();
      do_run($sformatf("rand%0d_run", r));
    end

`ifdef PROG_LOADER_TIMEOUT_EN
    // Done on the same edge the timeout would fire: done must win.
    rand_words(2);
    do_load("edge", 0, 1'b1);
    seq_q.delete();
    for (int i = 0; i < MAXC - 1; i++) seq_q.push_back(1'b0);
    seq_q.push_back(1'b1);
    do_run("edge_run");
    // No done at all: the run ends on the timeout.
    rand_words(2);
    do_load("tmo", 0, 1'b1);
    seq_q.delete();
    for (int i = 0; i < MAXC + 5; i++) seq_q.push_back(1'b0);
    do_run("tmo_run");
`endif

    // Full memory without in_last: address 4095 ends the load.
    rand_words(4096);
    do_load("full", 10, 1'b0);
    make_rand_seq();
    do_run("full_run");

    // Reset in the middle of a run.
    rand_words(2);
    do_load("pre_rst", 0, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    check("rst_run_cpu_start", 32'(cpu_start), 32'd1);
    check("rst_run_in_ready", 32'(in_ready), 32'd0);
    check("rst_run_prog_len", 32'(prog_len), 32'd0);
    check("rst_run_busy", 32'(busy), 32'd0);
    check("rst_run_run_cycles", 32'(run_cycles), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_cpu_start", 32'(cpu_start), 32'd1);
    rand_words(2);
    do_load("post_rst", 0, 1'b1);
    make_rand_seq();
    do_run("post_rst_run");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
